// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared definitions for the data-memory load/store unit:
//             access-size encoding, FSM state type, and default memory-map
//             constants (RAM base address, halt magic word).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    // req_size encoding
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } lsu_state_e;

    localparam logic [31:0] LSU_BASE_ADDR = 32'h1001_0000;
    localparam logic [31:0] LSU_HALT_WORD = 32'ha060_2880;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/dmem_sp_ram.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_sp_ram
//  Purpose  : Single-port synchronous data RAM, write-first, no reset.
//  Ports    : clk          rising-edge clock
//             en_i         port enable (read or write this edge)
//             we_i         write enable (qualified by en_i)
//             addr_i       word address
//             wdata_i      write data
//             rdata_o      registered read data (write data on a write)
//  Revision : 1.0  initial release
// ============================================================================
module dmem_sp_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
                rdata_q       <= wdata_i;
            end else begin
                rdata_q       <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule : dmem_sp_ram
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_lsu
//  Purpose  : Load/store unit with integrated single-port data RAM.
//             Request/response handshake, read-modify-write for sub-word
//             stores, misalignment/range error detection, sticky halt on a
//             store of the magic halt word.
//  Ports    : clk, rst (async, active low)
//             req_valid/req_ready/req_we/req_size/req_sign/req_addr/req_wdata
//             rsp_valid/rsp_rdata/rsp_err  one-cycle response
//             halt                         sticky halt flag
//  Revision : 1.0  initial release
// ============================================================================
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int          DATA_W    = 32,     // 32 or 64 only
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = LSU_BASE_ADDR,
    parameter logic [31:0] HALT_WORD = LSU_HALT_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              halt
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int AW    = $clog2(DEPTH);
    // Clears the lane bits below a 32-bit boundary in a byte-shift amount.
    localparam logic [OFF_W+2:0] SUB32_MASK = (OFF_W + 3)'(31);

    // Right-align the addressed bytes and zero/sign-extend to DATA_W.
    function automatic logic [DATA_W-1:0] f_extract(
        input logic [DATA_W-1:0] dout,
        input logic [OFF_W-1:0]  lane,
        input logic [1:0]        size,
        input logic              sign
    );
        logic [DATA_W-1:0] sh, mask, top;
        sh   = dout >> {lane, 3'b000};
        mask = ~({DATA_W{1'b1}} << (8 << size));
        top  = mask ^ (mask >> 1);   // MSB of the access
        f_extract = sh & mask;
        if (sign && |(sh & top)) begin
            f_extract = f_extract | ~mask;
        end
    endfunction

    // Overlay the low bytes of wdata onto the addressed lanes of dout.
    function automatic logic [DATA_W-1:0] f_merge(
        input logic [DATA_W-1:0] dout,
        input logic [DATA_W-1:0] wdata,
        input logic [OFF_W-1:0]  lane,
        input logic [1:0]        size
    );
        logic [DATA_W-1:0] bmask;
        bmask   = (~({DATA_W{1'b1}} << (8 << size))) << {lane, 3'b000};
        f_merge = (dout & ~bmask) | ((wdata << {lane, 3'b000}) & bmask);
    endfunction

    lsu_state_e        state_q;
    logic              ready_q, rsp_valid_q, rsp_err_q, halt_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              we_q, sign_q;
    logic [1:0]        size_q;
    logic [OFF_W-1:0]  lane_q;
    logic [AW-1:0]     idx_q;
    logic [DATA_W-1:0] wdata_q;

    logic [31:0]       w_off, w_idx;
    logic              w_misalign, w_err, w_accept, w_full_st, w_to_merge;
    logic              w_ram_en, w_ram_we, w_hmatch;
    logic [AW-1:0]     w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata, w_ram_rdata;
    logic [OFF_W-1:0]  w_wr_lane;
    logic [OFF_W+2:0]  w_h32_sh;
    logic              ready_d, halt_d;

    assign w_off = req_addr - BASE_ADDR;
    assign w_idx = w_off >> OFF_W;

    always_comb begin
        w_misalign = 1'b0;
        case (req_size)
            SZ_HALF:  w_misalign = w_off[0];
            SZ_WORD:  w_misalign = |w_off[1:0];
            SZ_DWORD: w_misalign = (|w_off[2:0]) || (DATA_W == 32);
            default:  w_misalign = 1'b0;
        endcase
    end

    assign w_err      = (req_addr < BASE_ADDR) || (w_idx >= 32'(DEPTH)) || w_misalign;
    assign w_accept   = req_valid && ready_q;
    assign w_full_st  = req_we && (req_size == 2'(OFF_W));
    assign w_to_merge = (state_q == ST_IDLE) && w_accept && !w_err && !w_full_st;

    // One RAM port: IDLE uses it for the accept-edge access, MERGE for the
    // read-modify-write write-back.
    always_comb begin
        if (state_q == ST_MERGE) begin
            w_ram_en    = we_q;
            w_ram_we    = we_q;
            w_ram_addr  = idx_q;
            w_ram_wdata = f_merge(w_ram_rdata, wdata_q, lane_q, size_q);
            w_wr_lane   = lane_q;
        end else begin
            w_ram_en    = w_accept && !w_err;
            w_ram_we    = w_accept && !w_err && w_full_st;
            w_ram_addr  = w_idx[AW-1:0];
            w_ram_wdata = req_wdata;
            w_wr_lane   = w_off[OFF_W-1:0];
        end
    end

    // Compare the aligned 32-bit slice holding the stored bytes.
    assign w_h32_sh = {w_wr_lane, 3'b000} & ~SUB32_MASK;
    assign w_hmatch = (32'(w_ram_wdata >> w_h32_sh) == HALT_WORD);

    assign halt_d  = halt_q || (w_ram_we && w_hmatch);
    assign ready_d = !w_to_merge && !halt_d;

    dmem_sp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .en_i    (w_ram_en),
        .we_i    (w_ram_we),
        .addr_i  (w_ram_addr),
        .wdata_i (w_ram_wdata),
        .rdata_o (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            halt_q      <= 1'b0;
            we_q        <= 1'b0;
            sign_q      <= 1'b0;
            size_q      <= SZ_BYTE;
            lane_q      <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            halt_q      <= halt_d;
            ready_q     <= ready_d;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        we_q    <= req_we;
                        sign_q  <= req_sign;
                        size_q  <= req_size;
                        lane_q  <= w_off[OFF_W-1:0];
                        idx_q   <= w_idx[AW-1:0];
                        wdata_q <= req_wdata;
                        if (w_err) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (w_full_st) begin
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_MERGE;
                        end
                    end
                end
                ST_MERGE: begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= we_q ? '0 : f_extract(w_ram_rdata, lane_q, size_q, sign_q);
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign halt      = halt_q;

endmodule : dmem_lsu
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_lsu
//  Purpose  : Directed self-checking bench for dmem_lsu, one 32-bit and one
//             64-bit instance sharing clock, reset and request fields.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v32 = 1'b0, v64 = 1'b0;
    logic        req_we = 1'b0, req_sign = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'h0;
    logic [63:0] req_wdata = 64'h0;

    logic        rdy32, rv32, err32, hlt32;
    logic [31:0] rd32;
    logic        rdy64, rv64, err64, hlt64;
    logic [63:0] rd64;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.DATA_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .req_valid(v32), .req_ready(rdy32),
        .req_we(req_we), .req_size(req_size), .req_sign(req_sign),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .rsp_valid(rv32), .rsp_rdata(rd32), .rsp_err(err32), .halt(hlt32)
    );

    dmem_lsu #(.DATA_W(64)) u_dut64 (
        .clk(clk), .rst(rst), .req_valid(v64), .req_ready(rdy64),
        .req_we(req_we), .req_size(req_size), .req_sign(req_sign),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv64), .rsp_rdata(rd64), .rsp_err(err64), .halt(hlt64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Issue one request, scramble the fields right after accept, and wait
    // (bounded) for the response. lat=0 means no response arrived.
    task automatic do_req(input bit sel64, input bit we, input logic [1:0] size,
                          input bit sign, input logic [31:0] addr, input logic [63:0] wdata,
                          output int lat, output logic [63:0] rdata,
                          output bit err, output bit hlt, output bit rdy);
        @(negedge clk);
        req_we = we; req_size = size; req_sign = sign; req_addr = addr; req_wdata = wdata;
        if (sel64) v64 = 1'b1; else v32 = 1'b1;
        @(posedge clk);
        #1;
        v32 = 1'b0; v64 = 1'b0;
        req_we = ~we; req_size = ~size; req_sign = ~sign;
        req_addr = 32'hDEAD_BEEF; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        lat = 0; rdata = '0; err = 1'b0; hlt = 1'b0; rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (sel64 ? rv64 : rv32) begin
                lat   = i;
                rdata = sel64 ? rd64 : {32'h0, rd32};
                err   = sel64 ? err64 : err32;
                hlt   = sel64 ? hlt64 : hlt32;
                rdy   = sel64 ? rdy64 : rdy32;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        logic [63:0] rd;
        bit          er, hl, ry;

        // ---------------- reset values ----------------
        #12;
        check("rst_ready", rdy32, 0);
        check("rst_rvalid", rv32, 0);
        check("rst_rdata", rd32, 0);
        check("rst_err", err32, 0);
        check("rst_halt", hlt32, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", rdy32, 1);

        // ---------------- DATA_W = 32 ----------------
        do_req(0, 1, 2'd2, 0, 32'h1001_0000, 64'h1122_3344, lat, rd, er, hl, ry);
        check("sw_lat", lat, 1);
        check("sw_err", er, 0);
        check("sw_rdata", rd, 0);

        do_req(0, 0, 2'd0, 1, 32'h1001_0001, 0, lat, rd, er, hl, ry);
        check("lb_lat", lat, 2);
        check("lb_data", rd, 64'h33);
        check("lb_ready_in_rsp", ry, 1);

        do_req(0, 1, 2'd0, 0, 32'h1001_0002, 64'h1234_5680, lat, rd, er, hl, ry);
        check("sb_lat", lat, 2);
        check("sb_rdata", rd, 0);

        do_req(0, 0, 2'd2, 0, 32'h1001_0000, 0, lat, rd, er, hl, ry);
        check("lw_merged", rd, 64'h1180_3344);

        do_req(0, 0, 2'd0, 1, 32'h1001_0002, 0, lat, rd, er, hl, ry);
        check("lb_signed", rd, 64'hFFFF_FF80);
        do_req(0, 0, 2'd0, 0, 32'h1001_0002, 0, lat, rd, er, hl, ry);
        check("lbu", rd, 64'h80);
        do_req(0, 0, 2'd1, 1, 32'h1001_0002, 0, lat, rd, er, hl, ry);
        check("lh_signed_pos", rd, 64'h1180);

        do_req(0, 0, 2'd1, 0, 32'h1001_0001, 0, lat, rd, er, hl, ry);
        check("lh_misalign_lat", lat, 1);
        check("lh_misalign_err", er, 1);
        check("lh_misalign_rdata", rd, 0);

        do_req(0, 0, 2'd2, 0, 32'h1001_1000, 0, lat, rd, er, hl, ry);
        check("oor_err", er, 1);
        do_req(0, 0, 2'd2, 0, 32'h1000_FFFC, 0, lat, rd, er, hl, ry);
        check("below_base_err", er, 1);
        do_req(0, 0, 2'd3, 0, 32'h1001_0000, 0, lat, rd, er, hl, ry);
        check("dword_on_32_err", er, 1);
        // an erroring store must not touch the RAM
        do_req(0, 1, 2'd2, 0, 32'h1001_0002, 64'h5555_5555, lat, rd, er, hl, ry);
        check("sw_misalign_err", er, 1);

        do_req(0, 1, 2'd2, 0, 32'h1001_0FFC, 64'hCAFE_F00D, lat, rd, er, hl, ry);
        check("last_word_st_err", er, 0);
        do_req(0, 0, 2'd2, 0, 32'h1001_0FFC, 0, lat, rd, er, hl, ry);
        check("last_word_ld", rd, 64'hCAFE_F00D);

        do_req(0, 0, 2'd2, 0, 32'h1001_0000, 0, lat, rd, er, hl, ry);
        check("no_write_on_err", rd, 64'h1180_3344);

        // ---------------- DATA_W = 64 ----------------
        do_req(1, 1, 2'd3, 0, 32'h1001_0008, 64'h0123_4567_89AB_CDEF, lat, rd, er, hl, ry);
        check("sd64_lat", lat, 1);
        do_req(1, 0, 2'd2, 0, 32'h1001_000C, 0, lat, rd, er, hl, ry);
        check("lwu64_hi", rd, 64'h0000_0000_0123_4567);
        do_req(1, 0, 2'd2, 1, 32'h1001_0008, 0, lat, rd, er, hl, ry);
        check("lw64_signed", rd, 64'hFFFF_FFFF_89AB_CDEF);
        do_req(1, 0, 2'd0, 0, 32'h1001_000F, 0, lat, rd, er, hl, ry);
        check("lbu64_lane7", rd, 64'h01);
        do_req(1, 0, 2'd3, 0, 32'h1001_0008, 0, lat, rd, er, hl, ry);
        check("ld64_lat", lat, 2);
        check("ld64_data", rd, 64'h0123_4567_89AB_CDEF);
        do_req(1, 0, 2'd3, 0, 32'h1001_000C, 0, lat, rd, er, hl, ry);
        check("ld64_misalign_err", er, 1);
        do_req(1, 1, 2'd2, 0, 32'h1001_0014, 64'hA060_2880, lat, rd, er, hl, ry);
        check("halt64_hi_lat", lat, 2);
        check("halt64_hi", hl, 1);

        // ---------------- reset during MERGE ----------------
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd1; req_sign = 1'b0;
        req_addr = 32'h1001_0000; req_wdata = 64'hBEEF;
        v32 = 1'b1;
        @(posedge clk);
        #1 v32 = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        check("mm_no_rsp_c1", rv32, 0);
        @(negedge clk);
        check("mm_no_rsp_c2", rv32, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        do_req(0, 0, 2'd2, 0, 32'h1001_0000, 0, lat, rd, er, hl, ry);
        check("mm_write_dropped", rd, 64'h1180_3344);

        // ---------------- halt ----------------
        do_req(0, 1, 2'd2, 0, 32'h1001_0010, 64'hA060_2880, lat, rd, er, hl, ry);
        check("halt_lat", lat, 1);
        check("halt_with_rsp", hl, 1);
        check("halt_ready_low", ry, 0);
        req_we = 1'b0; req_size = 2'd2; req_addr = 32'h1001_0000;
        v32 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("halt_no_accept", rv32, 0);
        end
        v32 = 1'b0;
        check("halt_ready_stays_low", rdy32, 0);
        check("halt_sticky", hlt32, 1);
        rst = 1'b0;
        #1;
        check("halt_cleared_by_rst", hlt32, 0);
        @(negedge clk);
        rst = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_dmem_lsu
`default_nettype wire

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised load/store unit plus single-port data RAM, the next generation of the CPU data-memory path. It replaces the purely combinational byte-cut/merge logic with a request/response handshake, performs read-modify-write for sub-word stores, and flags misaligned or out-of-range accesses. It also owns the sticky halt detector (magic store word). It sits between the pipeline MEM stage and the register-file write-back mux.

## Interface
- DATA_W, 32: RAM word width; only 32 or 64 are legal.
- DEPTH, 1024: RAM depth in DATA_W words.
- BASE_ADDR, 32'h1001_0000: byte address of RAM word 0.
- HALT_WORD, 32'ha060_2880: store value that raises halt.
- Derived: LANES = DATA_W/8; OFF_W = log2(LANES).

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE with halt low.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (DATA_W=64 only).
- req_sign  in  1  loads: sign-extend when 1, zero-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  load result, extended to DATA_W; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid; access was rejected.
- halt  out  1  sticky; set when a store writes HALT_WORD.

## Operation
- Accept: req_valid && req_ready at a rising edge.
- Offset: off = req_addr - BASE_ADDR. Word index = off >> OFF_W; lane = off[OFF_W-1:0].
- Error conditions; any one of these sets rsp_err:
  - req_addr < BASE_ADDR;
  - index >= DEPTH;
  - half access with off[0] != 0;
  - word access with off[1:0] != 0;
  - dword access with off[2:0] != 0;
  - size 3 when DATA_W = 32.
- An erroring request makes no RAM access.
- Full-width store (size = log2(LANES)): RAM is written at the accept edge; FSM stays IDLE.
- Load or sub-word store: RAM is read at the accept edge; FSM moves IDLE -> MERGE.
- MERGE, load: select lane bytes from RAM dout, extend per req_sign, register into rsp_rdata.
- MERGE, sub-word store: replace the addressed bytes of dout with the low bytes of req_wdata; write the merged word at the MERGE exit edge.
- MERGE always returns to IDLE after one cycle.
- Request fields are latched at accept; later input changes are ignored.
- Halt: on any RAM write, compare the aligned 32-bit lane containing the store against HALT_WORD. On a match, halt is set after that edge and stays set until reset; req_ready then stays 0.

## Timing
- Reset values: req_ready 0 during reset, 1 after; rsp_valid 0; rsp_rdata 0; rsp_err 0; halt 0; FSM IDLE. RAM contents are not cleared.
- Latency, measured from accept cycle 0:
  - full-width store or error: rsp_valid in cycle 1;
  - load or sub-word store: rsp_valid in cycle 2.
- Throughput: req_ready is low during MERGE and high again in the rsp_valid cycle, so back-to-back requests are allowed. A response and a new accept can share a cycle.
- A load immediately after a store to the same word returns the new data; the RAM is write-first and the write has completed before the read.
- Reset mid-MERGE: the pending write is dropped and no rsp_valid is issued.
- Halt and rsp_valid for the triggering store assert in the same cycle.

## Structure
- Package lsu_pkg holds: the size encoding constants, the FSM state enum (IDLE, MERGE), and the default BASE_ADDR and HALT_WORD.
- Sub-module dmem_sp_ram(DATA_W, DEPTH): synchronous read, write-first, single port, no reset.
- Extract/merge logic stays inline as combinational functions in dmem_lsu.

## Test plan
- DATA_W=32. Store word 0x11223344 @0x10010000, then load byte signed @0x10010001 -> rsp_rdata 0x00000033, rsp_valid in cycle 2.
- Store byte 0x80 @0x10010002, then load word @0x10010000 -> 0x11803344. Load byte signed @0x10010002 -> 0xFFFFFF80; unsigned -> 0x00000080.
- Load half @0x10010001 -> rsp_err=1 in cycle 1, rsp_rdata 0. Load @0x10011000 (DEPTH=1024) -> rsp_err=1.
- Store word 0xa0602880 @0x10010010 -> halt=1 with rsp_valid; req_ready stays 0 afterwards; assert rst low -> halt 0.
- DATA_W=64. Store dword 0x0123456789ABCDEF @0x10010008, then load word unsigned @0x1001000C -> 0x0000000001234567.
- Issue a half store, assert rst low during MERGE -> no rsp_valid; a later load of that word returns the pre-store value.
